i2c_slave_regfile: RTL and testbench
====================================

# i2c_slave_regfile

Parametrised I2C slave with an internal byte register file, register-pointer addressing and multi-byte auto-increment transfers. It is the next generation of the team's single-byte I2C slave. It adds:
- pointer/register semantics;
- repeated-start reads;
- master ACK/NACK handling;
- out-of-range NACK;
- a host-side port so on-chip logic can read and write the same registers.

It sits between the open-drain pad logic (`sda_oen`, with 0 = drive low) and the system control plane.

## Interface
- `SLAVE_ADDR`, default 7'h50: 7-bit device address.
- `REG_DEPTH`, default 16: number of 8-bit registers, 2..256.
- `FILTER_LEN`, default 2: SCL/SDA glitch-filter length in clk cycles, 1..15.
- `PTR_W`, derived: $clog2(REG_DEPTH), minimum 1.

Ports:
- `clk` in 1: system clock, at least 20x SCL rate.
- `rst` in 1: asynchronous, active-high reset.
- `scl_in` in 1: raw SCL.
- `sda_in` in 1: raw SDA.
- `sda_oen` out 1: SDA output enable, active-low. 0 = pull SDA low; reset value 1.
- `host_we` in 1: host register write strobe.
- `host_addr` in PTR_W: host register index, for both read and write.
- `host_wdata` in 8: host write data.
- `host_rdata` out 8: reg[host_addr], registered with 1-cycle latency; reset value 0.
- `i2c_wr_pulse` out 1: 1-cycle pulse per register written over I2C; reset value 0.
- `i2c_wr_addr` out PTR_W: index of that write; reset value 0.
- `i2c_wr_data` out 8: data of that write; reset value 0.
- `busy` out 1: high from an addressed START until STOP; reset value 0.
- `flag_start` out 1: 1-cycle pulse on START or repeated START; reset value 0.
- `flag_stop` out 1: 1-cycle pulse on STOP; reset value 0.

## Operation
- **Line conditioning.** SCL and SDA are each filtered, then edge-detected, giving scl_pos, scl_neg, sda_pos and sda_neg.
  - START = sda_neg while SCL high.
  - STOP = sda_pos while SCL high.
  - Both are recognised in every state. START goes to ADDR; STOP goes to IDLE.
- **State machine.** States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE.
- **Bit counter.** A 3-bit counter is cleared on entry to every byte state. Input bits are sampled on scl_pos. Byte-state exit happens on the 8th scl_neg.
- **ADDR.**
  - Match {addr[7:1]} == SLAVE_ADDR goes to ADDR_ACK and latches rw = bit 0.
  - Mismatch goes to IGNORE; no ACK is driven.
- **ADDR_ACK.** sda_oen is driven 0 for one SCL period. On its scl_neg, rw=0 goes to PTR and rw=1 goes to RD.
- **PTR.**
  - Received byte < REG_DEPTH: load the pointer and go to PTR_ACK with ACK.
  - Otherwise: no ACK (NACK) and go to IGNORE.
- **PTR_ACK and WR_ACK.** Both drive ACK and then go to WR.
- **WR.** At the 8th scl_neg:
  - write reg[ptr];
  - pulse i2c_wr_pulse with the address and data;
  - increment ptr, wrapping REG_DEPTH-1 to 0;
  - go to WR_ACK.
- **RD.**
  - On entry, the shift register loads reg[ptr] and ptr increments (with wrap).
  - The MSB is driven first. sda_oen = shift[7] ? 1 : 0, and updates on each scl_neg.
  - After the 8th bit, go to RD_ACK with SDA released.
- **RD_ACK.** The master's bit is sampled on scl_pos.
  - 0 (ACK): return to RD on scl_neg.
  - 1 (NACK): go to IGNORE.
- **IGNORE.** SDA is released; the block waits for START or STOP.
- **Repeated START.** The pointer is preserved, which enables write-pointer-then-read sequences.
- **Host/I2C write collision.** If host_we and an I2C write hit the same register in the same cycle, the I2C write wins. Different registers are written in parallel.
- **Reset mid-transfer.**
  - FSM goes to IDLE and sda_oen to 1.
  - ptr and all registers reset to 0.

## Timing
- Filter plus edge-detect latency is FILTER_LEN+2 clk from a pad change to the pos/neg pulse.
- sda_oen changes exactly 1 clk after the detected scl_neg.
- i2c_wr_pulse is asserted the clk after the 8th scl_neg of a WR byte. Register contents are visible on host_rdata one clk later.
- flag_start and flag_stop are asserted 1 clk after detection.
- busy rises with the ADDR_ACK entry and falls with flag_stop.

## Structure
- Package `i2c_slave_pkg`: the state enum `i2c_state_t` and the constants `I2C_ACK=1'b0` and `I2C_NACK=1'b1`.
- One sub-module, `i2c_line_cond`, instantiated twice (SCL and SDA). It contains:
  - a 2-flop synchroniser;
  - a FILTER_LEN majority/stability filter;
  - an edge detector producing `pos`, `neg` and `level`.
- The register file is an inline flop array, REG_DEPTH x 8.

## Test plan
- Write reg: START, 0xA0, ptr 0x03, 0x5A, STOP.
  - ACK on all three bytes.
  - i2c_wr_pulse once, with addr=3 and data=0x5A.
  - host_rdata at host_addr=3 reads 0x5A.
- Burst wrap (REG_DEPTH=16): ptr 0x0F, data 0x11, 0x22.
  - reg[15]=0x11 and reg[0]=0x22.
  - Two wr pulses.
- Repeated-start read:
  - host pre-loads reg[4]=0xC3 and reg[5]=0x3C;
  - sequence is START 0xA0 0x04, Sr 0xA1, read 2 bytes (ACK then NACK), STOP;
  - SDA carries 0xC3 then 0x3C;
  - after the NACK, SDA is released and the block is in IGNORE.
- Wrong address 0xB0:
  - sda_oen stays 1 for the whole transfer;
  - busy stays 0;
  - no wr pulse.
- Out-of-range pointer 0x20:
  - NACK at the pointer ACK slot;
  - following data bytes do not change any register.
- Async reset asserted mid-RD:
  - sda_oen goes to 1 immediately;
  - all outputs return to their reset values;
  - a subsequent full write transaction succeeds.

Source files
------------

// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C slave register file.
package i2c_slave_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WR,
        WR_ACK,
        RD,
        RD_ACK,
        IGNORE
    } i2c_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_line_cond.sv
// Conditions one raw I2C line: 2-flop synchroniser, stability filter and
// edge detector. Pad change to pos/neg pulse takes FILTER_LEN+2 clk.
module i2c_line_cond #(
    parameter int FILTER_LEN = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pos,
    output logic neg,
    output logic level
);

    logic       sync_p0;
    logic       sync_p1;
    logic       level_dly;
    logic [3:0] stable_cnt;

    // Idle bus is high, so every flop resets to 1 to avoid a false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0    <= 1'b1;
            sync_p1    <= 1'b1;
            level      <= 1'b1;
            level_dly  <= 1'b1;
            stable_cnt <= '0;
        end else begin
            sync_p0   <= din;
            sync_p1   <= sync_p0;
            level_dly <= level;
            if (sync_p1 == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == 4'(FILTER_LEN - 1)) begin
                level      <= sync_p1;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 4'd1;
            end
        end
    end

    assign pos = level & ~level_dly;
    assign neg = ~level & level_dly;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C slave with a byte register file, pointer addressing, auto-increment
// bursts, repeated-start reads and a host-side register port.
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         REG_DEPTH  = 16,
    parameter int         FILTER_LEN = 2,
    parameter int         PTR_W      = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             sda_oen,
    input  logic             host_we,
    input  logic [PTR_W-1:0] host_addr,
    input  logic [7:0]       host_wdata,
    output logic [7:0]       host_rdata,
    output logic             i2c_wr_pulse,
    output logic [PTR_W-1:0] i2c_wr_addr,
    output logic [7:0]       i2c_wr_data,
    output logic             busy,
    output logic             flag_start,
    output logic             flag_stop
);

    import i2c_slave_pkg::*;

    logic scl_pos, scl_neg, scl_lvl;
    logic sda_pos, sda_neg, sda_lvl;

    i2c_line_cond #(.FILTER_LEN(FILTER_LEN)) u_scl_cond (
        .clk   (clk),
        .rst   (rst),
        .din   (scl_in),
        .pos   (scl_pos),
        .neg   (scl_neg),
        .level (scl_lvl)
    );

    i2c_line_cond #(.FILTER_LEN(FILTER_LEN)) u_sda_cond (
        .clk   (clk),
        .rst   (rst),
        .din   (sda_in),
        .pos   (sda_pos),
        .neg   (sda_neg),
        .level (sda_lvl)
    );

    i2c_state_t       state_q, state_nxt;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_cnt;
    logic             byte_done;
    logic [PTR_W-1:0] ptr_q, ptr_inc;
    logic             rw_q;
    logic             mack_q;
    logic             oen_d;
    logic [7:0]       regs [REG_DEPTH];

    logic start_det, stop_det, byte_end, addr_match, ptr_ok;
    logic in_byte_state, entry, rd_load, wr_commit, ptr_load, host_in_range;

    assign start_det     = sda_neg & scl_lvl;
    assign stop_det      = sda_pos & scl_lvl;
    assign byte_end      = scl_neg & byte_done;
    assign addr_match    = (shift_q[7:1] == SLAVE_ADDR);
    assign ptr_ok        = ({1'b0, shift_q} < 9'(REG_DEPTH));
    assign host_in_range = ({1'b0, host_addr} < (PTR_W + 1)'(REG_DEPTH));
    assign ptr_inc       = (ptr_q == PTR_W'(REG_DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
    assign in_byte_state = (state_q == ADDR) || (state_q == PTR) ||
                           (state_q == WR)   || (state_q == RD);
    assign entry         = (state_nxt != state_q) || start_det;
    assign rd_load       = (state_nxt == RD) && (state_q != RD);
    assign wr_commit     = (state_q == WR)  && (state_nxt == WR_ACK);
    assign ptr_load      = (state_q == PTR) && (state_nxt == PTR_ACK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_nxt;
    end

    // START/STOP override whatever byte or ACK slot is in progress.
    always_comb begin
        state_nxt = state_q;
        if (start_det) begin
            state_nxt = ADDR;
        end else if (stop_det) begin
            state_nxt = IDLE;
        end else begin
            case (state_q)
                ADDR:     if (byte_end) state_nxt = addr_match ? ADDR_ACK : IGNORE;
                ADDR_ACK: if (scl_neg)  state_nxt = rw_q ? RD : PTR;
                PTR:      if (byte_end) state_nxt = ptr_ok ? PTR_ACK : IGNORE;
                PTR_ACK,
                WR_ACK:   if (scl_neg)  state_nxt = WR;
                WR:       if (byte_end) state_nxt = WR_ACK;
                RD:       if (byte_end) state_nxt = RD_ACK;
                RD_ACK:   if (scl_neg)  state_nxt = (mack_q == I2C_ACK) ? RD : IGNORE;
                default:  state_nxt = state_q;
            endcase
        end
    end

    always_comb begin
        shift_d = shift_q;
        if (rd_load) begin
            shift_d = regs[ptr_q];
        end else if ((state_q == RD) && scl_neg) begin
            shift_d = {shift_q[6:0], 1'b1};
        end else if (in_byte_state && (state_q != RD) && scl_pos) begin
            shift_d = {shift_q[6:0], sda_lvl};
        end
    end

    // Looking at the next state lets the registered sda_oen move one clk after scl_neg.
    always_comb begin
        oen_d = I2C_NACK;
        case (state_nxt)
            ADDR_ACK, PTR_ACK, WR_ACK: oen_d = I2C_ACK;
            RD:                        oen_d = shift_d[7];
            default:                   oen_d = I2C_NACK;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q      <= '0;
            bit_cnt      <= '0;
            byte_done    <= 1'b0;
            ptr_q        <= '0;
            rw_q         <= 1'b0;
            mack_q       <= I2C_NACK;
            sda_oen      <= 1'b1;
            i2c_wr_pulse <= 1'b0;
            i2c_wr_addr  <= '0;
            i2c_wr_data  <= '0;
            busy         <= 1'b0;
            flag_start   <= 1'b0;
            flag_stop    <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            sda_oen      <= oen_d;
            flag_start   <= start_det;
            flag_stop    <= stop_det;
            i2c_wr_pulse <= wr_commit;
            if (entry) begin
                bit_cnt   <= '0;
                byte_done <= 1'b0;
            end else if (in_byte_state && scl_pos) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) byte_done <= 1'b1;
            end
            if (wr_commit) begin
                i2c_wr_addr <= ptr_q;
                i2c_wr_data <= shift_q;
            end
            // Pointer survives repeated START so write-pointer-then-read works.
            if (ptr_load)                  ptr_q <= shift_q[PTR_W-1:0];
            else if (wr_commit || rd_load) ptr_q <= ptr_inc;
            if ((state_q == ADDR) && (state_nxt == ADDR_ACK)) rw_q <= shift_q[0];
            if ((state_q == RD_ACK) && scl_pos) mack_q <= sda_lvl;
            if (stop_det)                                          busy <= 1'b0;
            else if ((state_nxt == ADDR_ACK) && (state_q != ADDR_ACK)) busy <= 1'b1;
        end
    end

    // I2C write is applied last so it wins a same-register collision with the host.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
        end else begin
            if (host_we && host_in_range) regs[host_addr] <= host_wdata;
            if (wr_commit)                regs[ptr_q]     <= shift_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                host_rdata <= '0;
        else if (host_in_range) host_rdata <= regs[host_addr];
        else                    host_rdata <= '0;
    end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: a bit-banged open-drain master plus
// host-port accesses, checked against hand-computed values.
module tb_i2c_slave_regfile;

    import i2c_slave_pkg::*;

    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       host_we = 1'b0;
    logic [3:0] host_addr = 4'd0;
    logic [7:0] host_wdata = 8'd0;
    logic       sda_oen;
    logic [7:0] host_rdata;
    logic       i2c_wr_pulse;
    logic [3:0] i2c_wr_addr;
    logic [7:0] i2c_wr_data;
    logic       busy, flag_start, flag_stop;
    logic       sda_bus;

    assign sda_bus = sda_m & sda_oen;

    i2c_slave_regfile #(
        .SLAVE_ADDR (7'h50),
        .REG_DEPTH  (16),
        .FILTER_LEN (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .scl_in       (scl),
        .sda_in       (sda_bus),
        .sda_oen      (sda_oen),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_rdata   (host_rdata),
        .i2c_wr_pulse (i2c_wr_pulse),
        .i2c_wr_addr  (i2c_wr_addr),
        .i2c_wr_data  (i2c_wr_data),
        .busy         (busy),
        .flag_start   (flag_start),
        .flag_stop    (flag_stop)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0, oen_low_cnt = 0, busy_cnt = 0, start_cnt = 0, stop_cnt = 0;
    logic [3:0] last_addr = 4'd0;
    logic [7:0] last_data = 8'd0;

    always @(negedge clk) begin
        if (i2c_wr_pulse) begin
            wr_cnt    <= wr_cnt + 1;
            last_addr <= i2c_wr_addr;
            last_data <= i2c_wr_data;
        end
        if (!sda_oen)   oen_low_cnt <= oen_low_cnt + 1;
        if (busy)       busy_cnt    <= busy_cnt + 1;
        if (flag_start) start_cnt   <= start_cnt + 1;
        if (flag_stop)  stop_cnt    <= stop_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; tick(Q);
        scl   = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl   = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(Q);
        scl   = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic put_bit(input logic b);
        sda_m = b;    tick(Q);
        scl   = 1'b1; tick(Q);
        scl   = 1'b0; tick(Q);
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; tick(Q);
        scl   = 1'b1; tick(Q / 2);
        b     = sda_bus; tick(Q - Q / 2);
        scl   = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(ack);
    endtask

    task automatic recv_byte(input logic ack_bit, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) get_bit(d[i]);
        put_bit(ack_bit);
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        host_we = 1'b1; host_addr = a; host_wdata = d;
        @(posedge clk); #1;
        host_we = 1'b0;
    endtask

    task automatic host_read(input logic [3:0] a, output logic [7:0] d);
        host_addr = a;
        tick(2); #1;
        d = host_rdata;
    endtask

    logic       ack, b0, b1;
    logic [7:0] rd;
    int         wr0, oen0, busy0, st0, sp0;

    initial begin
        // Reset state
        tick(3); #1;
        check("rst_sda_oen", 32'(sda_oen), 32'h1);
        check("rst_host_rdata", 32'(host_rdata), 32'h0);
        check("rst_wr_pulse", 32'(i2c_wr_pulse), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_flags", 32'({flag_start, flag_stop}), 32'h0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        @(posedge clk); #1 rst = 1'b0;
        tick(Q);

        // Single register write: START A0 03 5A STOP
        wr0 = wr_cnt; st0 = start_cnt; sp0 = stop_cnt;
        bus_start();
        send_byte(8'hA0, ack); check("wr_addr_ack", 32'(ack), 32'h0);
        check("wr_busy_high", 32'(busy), 32'h1);
        send_byte(8'h03, ack); check("wr_ptr_ack", 32'(ack), 32'h0);
        send_byte(8'h5A, ack); check("wr_data_ack", 32'(ack), 32'h0);
        bus_stop();
        tick(Q);
        check("wr_pulse_count", 32'(wr_cnt - wr0), 32'h1);
        check("wr_pulse_addr", 32'(last_addr), 32'h3);
        check("wr_pulse_data", 32'(last_data), 32'h5A);
        check("wr_start_count", 32'(start_cnt - st0), 32'h1);
        check("wr_stop_count", 32'(stop_cnt - sp0), 32'h1);
        check("wr_busy_low", 32'(busy), 32'h0);
        host_read(4'd3, rd); check("wr_host_rd3", 32'(rd), 32'h5A);

        // Burst with pointer wrap: START A0 0F 11 22 STOP
        wr0 = wr_cnt;
        bus_start();
        send_byte(8'hA0, ack); check("wrap_addr_ack", 32'(ack), 32'h0);
        send_byte(8'h0F, ack); check("wrap_ptr_ack", 32'(ack), 32'h0);
        send_byte(8'h11, ack); check("wrap_d0_ack", 32'(ack), 32'h0);
        send_byte(8'h22, ack); check("wrap_d1_ack", 32'(ack), 32'h0);
        bus_stop();
        tick(Q);
        check("wrap_pulse_count", 32'(wr_cnt - wr0), 32'h2);
        check("wrap_last_addr", 32'(last_addr), 32'h0);
        host_read(4'd15, rd); check("wrap_reg15", 32'(rd), 32'h11);
        host_read(4'd0, rd);  check("wrap_reg0", 32'(rd), 32'h22);

        // Repeated-start read of host-loaded registers 4 and 5
        host_write(4'd4, 8'hC3);
        host_write(4'd5, 8'h3C);
        st0 = start_cnt;
        bus_start();
        send_byte(8'hA0, ack); check("rd_addr_ack", 32'(ack), 32'h0);
        send_byte(8'h04, ack); check("rd_ptr_ack", 32'(ack), 32'h0);
        bus_start();
        send_byte(8'hA1, ack); check("rd_addr_r_ack", 32'(ack), 32'h0);
        recv_byte(1'b0, rd);   check("rd_byte0", 32'(rd), 32'hC3);
        check("rd_busy", 32'(busy), 32'h1);
        recv_byte(1'b1, rd);   check("rd_byte1", 32'(rd), 32'h3C);
        check("rd_nack_released", 32'(sda_oen), 32'h1);
        check("rd_nack_ignore", 32'(dut.state_q), 32'(IGNORE));
        check("rd_start_count", 32'(start_cnt - st0), 32'h2);
        bus_stop();
        tick(Q);
        check("rd_idle", 32'(dut.state_q), 32'(IDLE));

        // Wrong device address 0xB0
        wr0 = wr_cnt; oen0 = oen_low_cnt; busy0 = busy_cnt;
        bus_start();
        send_byte(8'hB0, ack); check("bad_addr_nack", 32'(ack), 32'h1);
        send_byte(8'h12, ack); check("bad_data_nack", 32'(ack), 32'h1);
        bus_stop();
        tick(Q);
        check("bad_oen_low_cycles", 32'(oen_low_cnt - oen0), 32'h0);
        check("bad_busy_cycles", 32'(busy_cnt - busy0), 32'h0);
        check("bad_wr_count", 32'(wr_cnt - wr0), 32'h0);

        // Out-of-range pointer 0x20
        wr0 = wr_cnt;
        bus_start();
        send_byte(8'hA0, ack); check("oor_addr_ack", 32'(ack), 32'h0);
        send_byte(8'h20, ack); check("oor_ptr_nack", 32'(ack), 32'h1);
        send_byte(8'h77, ack); check("oor_data_nack", 32'(ack), 32'h1);
        bus_stop();
        tick(Q);
        check("oor_wr_count", 32'(wr_cnt - wr0), 32'h0);
        host_read(4'd0, rd); check("oor_reg0", 32'(rd), 32'h22);
        host_read(4'd6, rd); check("oor_reg6", 32'(rd), 32'h00);

        // Asynchronous reset in the middle of a read
        bus_start();
        send_byte(8'hA0, ack); check("mid_addr_ack", 32'(ack), 32'h0);
        send_byte(8'h04, ack); check("mid_ptr_ack", 32'(ack), 32'h0);
        bus_start();
        send_byte(8'hA1, ack); check("mid_addr_r_ack", 32'(ack), 32'h0);
        get_bit(b0);
        get_bit(b1);
        check("mid_first_bits", 32'({b0, b1}), 32'h3);
        check("mid_in_rd", 32'(dut.state_q), 32'(RD));
        check("mid_driving_low", 32'(sda_oen), 32'h0);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_oen", 32'(sda_oen), 32'h1);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_rdata", 32'(host_rdata), 32'h0);
        check("mid_rst_wr_data", 32'(i2c_wr_data), 32'h0);
        check("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
        sda_m = 1'b1;
        scl   = 1'b1;
        tick(Q);
        @(posedge clk); #1 rst = 1'b0;
        tick(Q);
        host_read(4'd4, rd); check("post_rst_reg4", 32'(rd), 32'h00);
        wr0 = wr_cnt;
        bus_start();
        send_byte(8'hA0, ack); check("post_addr_ack", 32'(ack), 32'h0);
        send_byte(8'h07, ack); check("post_ptr_ack", 32'(ack), 32'h0);
        send_byte(8'h9E, ack); check("post_data_ack", 32'(ack), 32'h0);
        bus_stop();
        tick(Q);
        check("post_wr_count", 32'(wr_cnt - wr0), 32'h1);
        check("post_wr_addr", 32'(last_addr), 32'h7);
        check("post_wr_data", 32'(last_data), 32'h9E);
        host_read(4'd7, rd); check("post_reg7", 32'(rd), 32'h9E);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
